// File: rtl/montred_unload.sv
// Final-correction and unload stage: optional word-serial a-m subtraction,
// then LSW-first streaming of the 3072-bit result over a valid/ready port.
module montred_unload #(
  parameter int Size    = 3072,
  parameter int W       = 64,
  parameter int N_WORDS = Size / W,
  parameter int CNT_W   = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [Size-1:0] new_a,
  input  logic [Size-1:0] m,
  input  logic            en_in,
  input  logic            last_in,
  input  logic            dout_ready,
  output logic [W-1:0]    dout,
  output logic            dout_valid,
  output logic            dout_last,
  output logic            sub_flag,
  output logic            busy,
  output logic            done,
  output logic            err_overrun
);

  typedef enum logic [1:0] {IDLE, SUB, SEL, OUT} state_t;
  typedef enum logic [1:0] {RES_HOLD, RES_NEW, RES_DIFF, RES_A} res_src_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic             borrow_q, borrow_d;
  logic             sub_flag_q, sub_flag_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [Size-1:0]  a_q, diff_q, res_q;
  logic             cap;
  logic             diff_we;
  res_src_t         res_src;

  logic [W:0]       sub_w;
  logic             k_end;

  assign k_end = (k_q == CNT_W'(N_WORDS - 1));

  // One word of a - m - borrow; the extra top bit is the outgoing borrow.
  assign sub_w = {1'b0, a_q[k_q*W +: W]} - {1'b0, m[k_q*W +: W]} - (W+1)'(borrow_q);

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    borrow_d   = borrow_q;
    sub_flag_d = sub_flag_q;
    done_d     = 1'b0;
    err_d      = err_q | (en_in && (state_q != IDLE));
    cap        = 1'b0;
    diff_we    = 1'b0;
    res_src    = RES_HOLD;
    case (state_q)
      IDLE: begin
        if (en_in) begin
          cap        = 1'b1;
          k_d        = '0;
          sub_flag_d = 1'b0;
          if (last_in) begin
            borrow_d = 1'b0;
            state_d  = SUB;
          end else begin
            res_src  = RES_NEW;
            state_d  = OUT;
          end
        end
      end
      SUB: begin
        diff_we  = 1'b1;
        borrow_d = sub_w[W];
        k_d      = k_q + 1'b1;
        if (k_end) state_d = SEL;
      end
      SEL: begin
        // No final borrow means a >= m, so the difference is the result.
        if (!borrow_q) begin
          res_src    = RES_DIFF;
          sub_flag_d = 1'b1;
        end else begin
          res_src    = RES_A;
          sub_flag_d = 1'b0;
        end
        k_d     = '0;
        state_d = OUT;
      end
      OUT: begin
        if (dout_ready) begin
          if (k_end) begin
            k_d     = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      k_q        <= '0;
      borrow_q   <= 1'b0;
      sub_flag_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      borrow_q   <= borrow_d;
      sub_flag_q <= sub_flag_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Data registers carry no reset; their contents only matter once loaded.
  always_ff @(posedge clk) begin
    if (cap) a_q <= new_a;
    if (diff_we) diff_q[k_q*W +: W] <= sub_w[W-1:0];
    case (res_src)
      RES_NEW:  res_q <= new_a;
      RES_DIFF: res_q <= diff_q;
      RES_A:    res_q <= a_q;
      default:  res_q <= res_q;
    endcase
  end

  assign dout_valid  = (state_q == OUT);
  assign dout        = dout_valid ? res_q[k_q*W +: W] : '0;
  assign dout_last   = dout_valid && k_end;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign sub_flag    = sub_flag_q;
  assign err_overrun = err_q;

endmodule

// File: doc/montred_unload.md
# montred_unload

Final-correction and unload stage for the Montgomery reduction datapath. Captures the 3072-bit `new_a` result from `phase_a` when `en_out` pulses. On the last iteration it applies the conditional subtraction `new_a >= m ? new_a - m : new_a` word-serially. It then streams the result LSW-first over a valid/ready word interface to the downstream consumer.

## Interface
- `Size`, 3072, operand/modulus width in bits
- `W`, 64, output word width; `Size % W == 0` required
- `N_WORDS`, `Size/W` (48), words per result
- `CNT_W`, 6, word-index counter width (`>= clog2(N_WORDS)`)

- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `new_a`  in  Size  reduced value from `phase_a`; sampled only when `en_in`=1 in IDLE
- `m`  in  Size  modulus; held stable by the source from capture to end of SUB
- `en_in`  in  1  capture strobe (driven by `phase_a.en_out`)
- `last_in`  in  1  sampled with `en_in`; 1 = final iteration, apply correction
- `dout_ready`  in  1  downstream accepts a word
- `dout`  out  W  current result word
- `dout_valid`  out  1  `dout` is valid
- `dout_last`  out  1  current word is word `N_WORDS-1`
- `sub_flag`  out  1  subtraction was applied to the current result
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse after the final handshake
- `err_overrun`  out  1  sticky; set when `en_in`=1 while busy

## Operation
- States: IDLE, SUB, SEL, OUT.
- IDLE:
  - If `en_in`=1, capture `new_a` into `a_reg`.
  - If `last_in`=1: go to SUB, clear `k` and `borrow`.
  - If `last_in`=0: set `res_reg`=`new_a`, `sub_flag`=0, go to OUT with `k`=0.
- SUB, one word per cycle for `k`=0..N_WORDS-1:
  - `{b, d} = a_reg[k*W +: W] - m[k*W +: W] - borrow`, computed at W+1 bits.
  - Write `d` to `diff_reg[k*W +: W]`; `borrow` <= `b`.
  - After `k`=N_WORDS-1, go to SEL.
- SEL, one cycle:
  - If final `borrow`=0 (`a >= m`): `res_reg`=`diff_reg`, `sub_flag`=1.
  - Otherwise: `res_reg`=`a_reg`, `sub_flag`=0.
  - Clear `k`; go to OUT.
- OUT:
  - `dout`=`res_reg[k*W +: W]`, `dout_valid`=1, `dout_last`=(`k`==N_WORDS-1).
  - On `dout_valid && dout_ready`: `k`++.
  - On the handshake with `dout_last`=1: go to IDLE and pulse `done` next cycle.
- Range: a single subtraction only. If `new_a >= 2m`, the output is `new_a - m`, not fully reduced. No error is flagged for this; the Montgomery bound `new_a < 2m` is the source's obligation.
- `en_in` while busy: the strobe is ignored, the current operation is unaffected, and `err_overrun` is set to 1. It is cleared only by reset.
- `en_in` in the same cycle as the final OUT handshake: ignored, because the state is still OUT. `err_overrun` is set.
- `sub_flag` is valid from OUT entry until the next capture.

## Timing
- Reset (`rst_n`=0 at a clock edge): state=IDLE. The following outputs and registers are 0: `dout`, `dout_valid`, `dout_last`, `sub_flag`, `busy`, `done`, `err_overrun`, `k`, `borrow`. Data registers are don't-care.
- Reset mid-operation: the in-flight result is dropped and no `done` pulse is issued.
- Capture at edge 0 with `last_in`=1:
  - SUB spans cycles 1..N_WORDS (48).
  - SEL occupies cycle N_WORDS+1 (49).
  - `dout_valid` first goes high in cycle N_WORDS+2 (50).
- Capture with `last_in`=0: `dout_valid` goes high in cycle 1.
- Backpressure: while `dout_valid`=1 and `dout_ready`=0, `dout` and `dout_last` hold stable. `dout_valid` never drops before its handshake.
- With `dout_ready` held at 1, one word transfers per cycle. `done` rises the cycle after the last handshake, and `busy`=0 in that same cycle. A new capture is accepted in that cycle.
- `busy`=1 from the cycle after capture through the last OUT cycle.

## Test plan
- `new_a`=`m`+5, `last_in`=1, `dout_ready`=1 -> `sub_flag`=1; word0=5, words 1..47=0. First `dout_valid` at cycle 50, `dout_last` at cycle 97, `done` at cycle 98.
- `new_a`=`m`-1, `last_in`=1 -> `sub_flag`=0; the 48 output words equal the words of `m`-1.
- `new_a`=`m` exactly -> `sub_flag`=1, all 48 words = 0. This checks the borrow boundary.
- `new_a`=all ones, `last_in`=0 -> no SUB phase; first `dout_valid` at cycle 1; all words = 64'hFFFF_FFFF_FFFF_FFFF; `sub_flag`=0.
- `dout_ready` toggling 1,0,1,0 during OUT -> 48 handshakes over 96 cycles. `dout` is stable on every stalled cycle, and no word is lost or duplicated.
- `en_in`=1 during OUT -> ignored, `err_overrun`=1, output unchanged. Then `rst_n`=0 for one cycle mid-SUB of a new operation -> next cycle state is IDLE, and `dout_valid`, `busy` and `err_overrun` are all 0.
